// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the calculator engine.
// Key codes, operator and state encodings, default sizing and the display
// limit helper used by calc_core and bin2bcd_seq.
package calc_pkg;

  localparam int DIGITS_DEF = 8;
  localparam int MAG_W_DEF  = 27;

  localparam logic [3:0] KEY_ADD  = 4'd10;
  localparam logic [3:0] KEY_SUB  = 4'd11;
  localparam logic [3:0] KEY_MUL  = 4'd12;
  localparam logic [3:0] KEY_EQ   = 4'd13;
  localparam logic [3:0] KEY_CLR  = 4'd14;
  localparam logic [3:0] KEY_BKSP = 4'd15;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_OP_WAIT = 3'd1,
    ST_ENTRY_B = 3'd2,
    ST_RESULT  = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  // 10^n, evaluated at elaboration time for parameter-derived limits
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint DISP_MAX = pow10(DIGITS_DEF) - 1;

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to packed BCD converter.
// One load cycle, MAG_W shift cycles, then done is held for one cycle while
// busy is still high so the consumer can latch o_bcd. A start while busy
// restarts the conversion with the new operand.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int MAG_W  = MAG_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_start,
  input  logic [MAG_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(MAG_W + 1);

  logic [MAG_W-1:0] r_bin;
  logic [BW-1:0]    r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BW-2:0]    w_adj;

  // Add 3 to every digit >= 5 before the shift. The top digit is never
  // adjusted: inputs stay below 10^DIGITS, so it holds at most 4 before the
  // final shift and only its low three bits move on.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS - 1; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
    end
  endgenerate
  assign w_adj[BW-2:BW-4] = r_bcd[BW-2:BW-4];

  // Load, shift MAG_W times, flag done, then drop busy on the following edge
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      if (r_done) begin
        r_busy <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_bcd <= {w_adj, r_bin[MAG_W-1]};
        r_bin <= {r_bin[MAG_W-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(MAG_W - 1)) r_done <= 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/calc_core.sv
// calc_core: keypad-driven calculator engine (operand entry, left-to-right
// operator chaining, +/-/* with range check) feeding a BCD display.
// Build option: define CALC_MUL_EN to enable key 12 as multiply; when it is
// undefined key 12 is ignored and no multiplier is built.
module calc_core
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int MAG_W  = MAG_W_DEF
) (
  input  logic                  sw_clk,
  input  logic                  rst,
  input  logic [4:0]            eBCD,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  err,
  output logic                  busy,
  output logic                  disp_upd
);

  localparam int AW = MAG_W + 1;
  localparam int PW = 2 * AW;
  localparam logic [MAG_W-1:0] DIG_LIM_M  = MAG_W'(pow10(DIGITS - 1));
  localparam logic [PW-1:0]    DISP_LIM_W = PW'(pow10(DIGITS) - 1);

  logic                     r_key_vld, r_key_vld_d;
  logic [3:0]               r_key_code;
  state_t                   r_state, w_state_next;
  op_t                      r_op, w_op_next, w_key_op;
  logic [MAG_W-1:0]         r_cur, w_cur_next, w_cur_app, w_cur_div, w_digit;
  logic signed [AW-1:0]     r_acc, w_acc_next, w_res_acc;
  logic [AW-1:0]            w_acc_next_mag;
  logic signed [PW-1:0]     w_a_ext, w_b_ext, w_res_wide;
  logic [PW-1:0]            w_res_mag;
  logic                     w_ovf, w_event, w_accept, w_is_digit, w_is_op, w_start;
  logic [MAG_W-1:0]         w_disp_mag;
  logic                     w_disp_neg;
  logic                     w_conv_busy, w_conv_done;
  logic [4*DIGITS-1:0]      w_conv_bcd;
  logic                     r_neg_pend, r_neg;
  logic [4*DIGITS-1:0]      r_bcd;
  logic                     r_disp_upd;

  // Register the key-valid level and code; an event is the registered 0->1 edge
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      r_key_vld   <= 1'b0;
      r_key_vld_d <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_key_vld   <= eBCD[4];
      r_key_vld_d <= r_key_vld;
      r_key_code  <= eBCD[3:0];
    end
  end

  assign w_event    = r_key_vld & ~r_key_vld_d;
  assign w_accept   = w_event & (~w_conv_busy | (r_key_code == KEY_CLR));
  assign w_is_digit = (r_key_code < 4'd10);
`ifdef CALC_MUL_EN
  assign w_is_op = (r_key_code == KEY_ADD) | (r_key_code == KEY_SUB) | (r_key_code == KEY_MUL);
`else
  assign w_is_op = (r_key_code == KEY_ADD) | (r_key_code == KEY_SUB);
`endif
  assign w_digit   = MAG_W'(r_key_code);
  assign w_cur_app = r_cur * MAG_W'(10) + w_digit;
  assign w_cur_div = r_cur / MAG_W'(10);

  // Map an operator key to its op encoding
  always_comb begin
    case (r_key_code)
      KEY_SUB: w_key_op = OP_SUB;
      KEY_MUL: w_key_op = OP_MUL;
      default: w_key_op = OP_ADD;
    endcase
  end

  // acc op cur at double width so the range check sees the true result
  assign w_a_ext = {{(PW-AW){r_acc[AW-1]}}, r_acc};
  assign w_b_ext = {{(PW-MAG_W){1'b0}}, r_cur};
  always_comb begin
    case (r_op)
      OP_ADD:  w_res_wide = w_a_ext + w_b_ext;
      OP_SUB:  w_res_wide = w_a_ext - w_b_ext;
`ifdef CALC_MUL_EN
      OP_MUL:  w_res_wide = w_a_ext * w_b_ext;
`endif
      default: w_res_wide = w_a_ext;
    endcase
  end
  assign w_res_mag = w_res_wide[PW-1] ? PW'(-w_res_wide) : PW'(w_res_wide);
  assign w_ovf     = (w_res_mag > DISP_LIM_W);
  assign w_res_acc = w_res_wide[AW-1:0];

  // State register plus operand/accumulator/operator
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      r_state <= ST_ENTRY_A;
      r_op    <= OP_NONE;
      r_cur   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_cur   <= w_cur_next;
      r_acc   <= w_acc_next;
    end
  end

  // Next state: every accepted key that has an effect also starts a conversion
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_cur_next   = r_cur;
    w_acc_next   = r_acc;
    w_start      = 1'b0;
    if (w_accept) begin
      if (r_key_code == KEY_CLR) begin
        w_state_next = ST_ENTRY_A;
        w_op_next    = OP_NONE;
        w_cur_next   = '0;
        w_acc_next   = '0;
        w_start      = 1'b1;
      end else if (r_state != ST_ERROR) begin
        if (w_is_digit) begin
          case (r_state)
            ST_ENTRY_A, ST_ENTRY_B: begin
              if (r_cur < DIG_LIM_M) begin
                w_cur_next = w_cur_app;
                w_start    = 1'b1;
              end
            end
            ST_OP_WAIT: begin
              w_cur_next   = w_digit;
              w_state_next = ST_ENTRY_B;
              w_start      = 1'b1;
            end
            ST_RESULT: begin
              w_acc_next   = '0;
              w_cur_next   = w_digit;
              w_state_next = ST_ENTRY_A;
              w_start      = 1'b1;
            end
            default: ;
          endcase
        end else if (w_is_op) begin
          w_start = 1'b1;
          case (r_state)
            ST_ENTRY_A: begin
              w_acc_next   = {1'b0, r_cur};
              w_op_next    = w_key_op;
              w_state_next = ST_OP_WAIT;
            end
            ST_ENTRY_B: begin
              if (w_ovf) begin
                w_state_next = ST_ERROR;
                w_cur_next   = '0;
                w_acc_next   = '0;
              end else begin
                w_acc_next   = w_res_acc;
                w_op_next    = w_key_op;
                w_state_next = ST_OP_WAIT;
              end
            end
            default: begin
              w_op_next    = w_key_op;
              w_state_next = ST_OP_WAIT;
            end
          endcase
        end else if (r_key_code == KEY_EQ) begin
          if (r_state == ST_ENTRY_B) begin
            w_start = 1'b1;
            if (w_ovf) begin
              w_state_next = ST_ERROR;
              w_cur_next   = '0;
              w_acc_next   = '0;
            end else begin
              w_acc_next   = w_res_acc;
              w_state_next = ST_RESULT;
            end
          end else if (r_state == ST_OP_WAIT) begin
            w_state_next = ST_RESULT;
            w_start      = 1'b1;
          end
        end else if (r_key_code == KEY_BKSP) begin
          if ((r_state == ST_ENTRY_A) || (r_state == ST_ENTRY_B)) begin
            w_cur_next = w_cur_div;
            w_start    = 1'b1;
          end
        end
      end
    end
  end

  assign w_acc_next_mag = w_acc_next[AW-1] ? -w_acc_next : w_acc_next;

  // Outputs: value to display after this key, error flag, busy
  always_comb begin
    w_disp_mag = '0;
    w_disp_neg = 1'b0;
    case (w_state_next)
      ST_ENTRY_A, ST_ENTRY_B: w_disp_mag = w_cur_next;
      ST_OP_WAIT, ST_RESULT: begin
        w_disp_mag = MAG_W'(w_acc_next_mag);
        w_disp_neg = w_acc_next[AW-1];
      end
      default: ;
    endcase
    err  = (r_state == ST_ERROR);
    busy = w_conv_busy;
  end

  bin2bcd_seq #(
    .DIGITS (DIGITS),
    .MAG_W  (MAG_W)
  ) u_bin2bcd (
    .i_clk   (sw_clk),
    .i_srst  (rst),
    .i_start (w_start),
    .i_bin   (w_disp_mag),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_conv_bcd)
  );

  // Publish the finished conversion together with its sign and a pulse
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      r_neg_pend <= 1'b0;
      r_neg      <= 1'b0;
      r_bcd      <= '0;
      r_disp_upd <= 1'b0;
    end else begin
      r_disp_upd <= 1'b0;
      if (w_start) r_neg_pend <= w_disp_neg;
      if (w_conv_done) begin
        r_bcd      <= w_conv_bcd;
        r_neg      <= r_neg_pend;
        r_disp_upd <= 1'b1;
      end
    end
  end

  assign bcd      = r_bcd;
  assign neg      = r_neg;
  assign disp_upd = r_disp_upd;

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed key sequences with hand-computed display values,
// latency and pulse counts for calc_core.
module tb_calc_core;

  localparam int MAG_W = 27;
`ifdef CALC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  ebcd;
  logic [31:0] bcd;
  logic        neg, err, busy, disp_upd;

  int n_checks = 0;
  int n_errors = 0;

  calc_core dut (
    .sw_clk   (clk),
    .rst      (rst),
    .eBCD     (ebcd),
    .bcd      (bcd),
    .neg      (neg),
    .err      (err),
    .busy     (busy),
    .disp_upd (disp_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run n cycles, sampling 1 time unit after each edge; index 0 is the first edge
  task automatic watch(input int ncyc, output int pulses, output int first_at);
    pulses   = 0;
    first_at = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (disp_upd) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  task automatic press_key(input string tag, input logic [3:0] code, input bit exp_upd,
                           input longint exp_bcd, input bit exp_neg);
    int p1, f1, p2, f2, first;
    @(negedge clk);
    ebcd = {1'b1, code};
    watch(3, p1, f1);
    ebcd = 5'h00;
    watch(MAG_W + 6, p2, f2);
    first = (f1 >= 0) ? f1 : ((f2 >= 0) ? f2 + 3 : -1);
    check({tag, "/lat"}, first, exp_upd ? MAG_W + 2 : -1);
    check({tag, "/upd"}, p1 + p2, exp_upd ? 1 : 0);
    check({tag, "/bcd"}, bcd, exp_bcd);
    check({tag, "/neg"}, neg, exp_neg);
    check({tag, "/busy"}, busy, 0);
    $display("key %-8s code=%0d bcd=%08h neg=%0b err=%0b upd=%0d lat=%0d",
             tag, code, bcd, neg, err, p1 + p2, first);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p, f, pa, fa, pt;
    rst  = 1'b1;
    ebcd = 5'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst/bcd", bcd, 0);
    check("rst/neg", neg, 0);
    check("rst/err", err, 0);
    check("rst/busy", busy, 0);
    check("rst/upd", disp_upd, 0);
    @(negedge clk);
    rst = 1'b0;
    $display("reset released bcd=%08h busy=%0b", bcd, busy);

    // 12 + 34 = 46
    press_key("d1", 4'd1, 1, 32'h1, 0);
    press_key("d2", 4'd2, 1, 32'h12, 0);
    press_key("add", 4'd10, 1, 32'h12, 0);
    press_key("d3", 4'd3, 1, 32'h3, 0);
    press_key("d4", 4'd4, 1, 32'h34, 0);
    press_key("eq", 4'd13, 1, 32'h46, 0);
    press_key("eq_again", 4'd13, 0, 32'h46, 0);

    // 5 - 9 = -4
    press_key("clr", 4'd14, 1, 32'h0, 0);
    press_key("d5", 4'd5, 1, 32'h5, 0);
    press_key("sub", 4'd11, 1, 32'h5, 0);
    press_key("d9", 4'd9, 1, 32'h9, 0);
    press_key("eq_neg", 4'd13, 1, 32'h4, 1);

    // 2 + 3 * 4 chained left to right, or MUL ignored when not built
    press_key("clr", 4'd14, 1, 32'h0, 0);
    press_key("m2", 4'd2, 1, 32'h2, 0);
    press_key("madd", 4'd10, 1, 32'h2, 0);
    press_key("m3", 4'd3, 1, 32'h3, 0);
    press_key("mul", 4'd12, MUL_ON, MUL_ON ? 32'h5 : 32'h3, 0);
    press_key("m4", 4'd4, 1, MUL_ON ? 32'h4 : 32'h34, 0);
    press_key("meq", 4'd13, 1, MUL_ON ? 32'h20 : 32'h36, 0);

    // Digit limit, backspace, overflow into ERROR and recovery by CLR
    press_key("clr", 4'd14, 1, 32'h0, 0);
    press_key("n1", 4'd9, 1, 32'h9, 0);
    press_key("n2", 4'd9, 1, 32'h99, 0);
    press_key("n3", 4'd9, 1, 32'h999, 0);
    press_key("n4", 4'd9, 1, 32'h9999, 0);
    press_key("n5", 4'd9, 1, 32'h99999, 0);
    press_key("n6", 4'd9, 1, 32'h999999, 0);
    press_key("n7", 4'd9, 1, 32'h9999999, 0);
    press_key("n8", 4'd9, 1, 32'h99999999, 0);
    press_key("n9_ign", 4'd9, 0, 32'h99999999, 0);
    press_key("bksp", 4'd15, 1, 32'h09999999, 0);
    press_key("n9b", 4'd9, 1, 32'h99999999, 0);
    press_key("oadd", 4'd10, 1, 32'h99999999, 0);
    press_key("o1", 4'd1, 1, 32'h1, 0);
    check("pre_ovf/err", err, 0);
    press_key("oeq", 4'd13, 1, 32'h0, 0);
    check("ovf/err", err, 1);
    press_key("err_dig", 4'd5, 0, 32'h0, 0);
    check("err_hold/err", err, 1);
    press_key("err_clr", 4'd14, 1, 32'h0, 0);
    check("clr/err", err, 0);

    // Held key gives one event
    @(negedge clk);
    ebcd = 5'h13;
    watch(40, p, f);
    ebcd = 5'h00;
    watch(5, pa, fa);
    check("hold/upd", p + pa, 1);
    check("hold/lat", f, MAG_W + 2);
    check("hold/bcd", bcd, 32'h3);
    $display("hold key 3 for 40 cycles bcd=%08h upd=%0d", bcd, p + pa);

    // Digit 7 during a conversion is dropped
    @(negedge clk);
    ebcd = 5'h11;
    watch(2, p, f);
    ebcd = 5'h00;
    watch(2, pa, fa);
    pt = p + pa;
    check("drop/busy", busy, 1);
    @(negedge clk);
    ebcd = 5'h17;
    watch(2, p, f);
    ebcd = 5'h00;
    watch(MAG_W + 6, pa, fa);
    pt = pt + p + pa;
    check("drop/upd", pt, 1);
    check("drop/bcd", bcd, 32'h31);
    $display("key 7 while busy bcd=%08h upd=%0d", bcd, pt);

    // CLR during a conversion aborts it and shows 0
    @(negedge clk);
    ebcd = 5'h12;
    watch(2, p, f);
    ebcd = 5'h00;
    watch(2, pa, fa);
    pt = p + pa;
    check("abort/busy", busy, 1);
    @(negedge clk);
    ebcd = 5'h1E;
    watch(2, p, f);
    ebcd = 5'h00;
    watch(MAG_W + 6, pa, fa);
    pt = pt + p + pa;
    check("abort/upd", pt, 1);
    check("abort/bcd", bcd, 32'h0);
    $display("clr while busy bcd=%08h upd=%0d", bcd, pt);

    // rst for one cycle mid-conversion
    press_key("r4", 4'd4, 1, 32'h4, 0);
    @(negedge clk);
    ebcd = 5'h18;
    watch(2, p, f);
    ebcd = 5'h00;
    watch(3, pa, fa);
    check("midrst/busy_before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst/bcd", bcd, 0);
    check("midrst/busy", busy, 0);
    check("midrst/upd", disp_upd, 0);
    @(negedge clk);
    rst = 1'b0;
    watch(MAG_W + 6, p, f);
    check("midrst/no_upd", p, 0);
    $display("rst mid-conversion bcd=%08h busy=%0b upd_after=%0d", bcd, busy, p);
    press_key("after_rst", 4'd6, 1, 32'h6, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
